// File: rtl/vga_sync_gen_if.sv
// Scan-position bundle between the VGA timing generator and the pixel-colour stages.
// The generator (master) takes the run enable and drives position, blanking and strobes.
interface vga_sync_gen_if;
  logic        en;
  logic [11:0] pixel_x;
  logic [11:0] pixel_y;
  logic        video_on;
  logic        hsync;
  logic        vsync;
  logic        pixel_tick;
  logic        frame_start;

  modport master (
    input  en,
    output pixel_x, pixel_y, video_on, hsync, vsync, pixel_tick, frame_start
  );

  modport slave (
    output en,
    input  pixel_x, pixel_y, video_on, hsync, vsync, pixel_tick, frame_start
  );
endinterface

// File: rtl/vga_sync_gen.sv
// Free-running VGA timing generator: clock divider, h/v scan counters and registered
// sync/blanking decodes that are always aligned with the published scan position.
module vga_sync_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  vga_sync_gen_if.master bus
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_VIS  = 12'(H_DISPLAY);
  localparam logic [11:0] V_VIS  = 12'(V_DISPLAY);

  // Index 0 = horizontal, 1 = vertical.
  localparam logic [11:0] SYNC_START [2] = '{12'(H_DISPLAY + H_FRONT),
                                             12'(V_DISPLAY + V_FRONT)};
  localparam logic [11:0] SYNC_STOP  [2] = '{12'(H_DISPLAY + H_FRONT + H_SYNC),
                                             12'(V_DISPLAY + V_FRONT + V_SYNC)};

  logic [DIV_W-1:0] div_reg, div_next;
  logic [11:0]      x_reg, x_next;
  logic [11:0]      y_reg, y_next;
  logic             tick_reg, tick_next;
  logic             frame_reg, frame_next;
  logic             video_reg, video_next;
  logic [1:0]       sync_reg, sync_next;
  logic [11:0]      pos_next [2];

  always_comb begin
    div_next   = div_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    tick_next  = 1'b0;
    frame_next = 1'b0;
    if (bus.en) begin
      if (div_reg == DIV_LAST) begin
        div_next  = '0;
        tick_next = 1'b1;
        if (x_reg == H_LAST) begin
          x_next = '0;
          if (y_reg == V_LAST) begin
            y_next     = '0;
            frame_next = 1'b1;
          end else begin
            y_next = y_reg + 12'd1;
          end
        end else begin
          x_next = x_reg + 12'd1;
        end
      end else begin
        div_next = div_reg + DIV_W'(1);
      end
    end
  end

  // Decodes look at the next-state position so they land on the same edge as the counters.
  assign pos_next[0] = x_next;
  assign pos_next[1] = y_next;
  assign video_next  = (x_next < H_VIS) && (y_next < V_VIS);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      assign sync_next[gi] = (pos_next[gi] >= SYNC_START[gi] && pos_next[gi] < SYNC_STOP[gi])
                             ? SYNC_POL : ~SYNC_POL;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_reg   <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
      tick_reg  <= 1'b0;
      frame_reg <= 1'b0;
      video_reg <= 1'b0;
      sync_reg  <= {2{~SYNC_POL}};
    end else begin
      div_reg   <= div_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      tick_reg  <= tick_next;
      frame_reg <= frame_next;
      // Held while paused so video_on keeps its post-reset 0 until counting starts.
      if (bus.en) begin
        video_reg <= video_next;
        sync_reg  <= sync_next;
      end
    end
  end

  assign bus.pixel_x     = x_reg;
  assign bus.pixel_y     = y_reg;
  assign bus.video_on    = video_reg;
  assign bus.hsync       = sync_reg[0];
  assign bus.vsync       = sync_reg[1];
  assign bus.pixel_tick  = tick_reg;
  assign bus.frame_start = frame_reg;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench: three generator builds share clk/rst/en; a counting model of the scan
// position (enabled clocks / CLK_DIV, folded into x,y) predicts every clock's outputs.
module tb_vga_sync_gen;

  localparam int NI   = 3;
  localparam int NCYC = 14000;
  localparam int HOLD_AT = 5000;
  localparam int MID_RST = 9000;

  localparam int CDIV [NI] = '{4, 1, 3};
  localparam int HD   [NI] = '{640, 8, 10};
  localparam int HF   [NI] = '{16, 2, 3};
  localparam int HS   [NI] = '{96, 3, 4};
  localparam int HB   [NI] = '{48, 2, 3};
  localparam int VD   [NI] = '{480, 6, 5};
  localparam int VF   [NI] = '{10, 1, 2};
  localparam int VS   [NI] = '{2, 2, 3};
  localparam int VB   [NI] = '{33, 2, 2};
  localparam bit POL  [NI] = '{1'b0, 1'b0, 1'b1};

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic        von;
    logic        hs;
    logic        vs;
    logic        tick;
    logic        fs;
  } snap_t;
  typedef snap_t [NI-1:0] trio_t;

  logic clk = 1'b0;
  logic rst;
  logic en;
  snap_t act_w [NI];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_inst
      vga_sync_gen_if bus ();
      assign bus.en = en;
      vga_sync_gen #(
        .CLK_DIV(CDIV[gi]), .H_DISPLAY(HD[gi]), .H_FRONT(HF[gi]), .H_SYNC(HS[gi]),
        .H_BACK(HB[gi]), .V_DISPLAY(VD[gi]), .V_FRONT(VF[gi]), .V_SYNC(VS[gi]),
        .V_BACK(VB[gi]), .SYNC_POL(POL[gi])
      ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
      );
      assign act_w[gi] = {bus.pixel_x, bus.pixel_y, bus.video_on, bus.hsync, bus.vsync,
                          bus.pixel_tick, bus.frame_start};
    end
  endgenerate

  // Reference: after n enabled clocks the scan has advanced n/CLK_DIV pixels.
  function automatic snap_t model(int i, longint n, bit any_en, bit tk);
    snap_t  s;
    longint ht = HD[i] + HF[i] + HS[i] + HB[i];
    longint vt = VD[i] + VF[i] + VS[i] + VB[i];
    longint p  = (n / CDIV[i]) % (ht * vt);
    int     x  = int'(p % ht);
    int     y  = int'(p / ht);
    s.x    = 12'(x);
    s.y    = 12'(y);
    s.von  = any_en && (x < HD[i]) && (y < VD[i]);
    s.hs   = (x >= HD[i] + HF[i] && x < HD[i] + HF[i] + HS[i]) ? POL[i] : ~POL[i];
    s.vs   = (y >= VD[i] + VF[i] && y < VD[i] + VF[i] + VS[i]) ? POL[i] : ~POL[i];
    s.tick = tk;
    s.fs   = tk && (p == 0);
    return s;
  endfunction

  trio_t  exp_q [$];
  int     total = 0;
  int     bad   = 0;
  longint n_en  [NI];
  bit     any_en[NI];
  bit     tk    [NI];

  task automatic push_state();
    trio_t e;
    for (int i = 0; i < NI; i++) e[i] = model(i, n_en[i], any_en[i], tk[i]);
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      n_en[i] = 0; any_en[i] = 1'b0; tk[i] = 1'b0;
    end
  endtask

  // Stimulus: random enable with a forced 10-clk pause, a power-on and a mid-run reset.
  initial begin
    int hold;
    rst = 1'b1;
    en  = 1'b0;
    hold = 3;
    model_reset();
    $display("reset asserted at %0t", $time);
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      if (rst) begin
        push_state();
        hold--;
        if (hold == 0) begin
          #3 rst = 1'b0;
        end
      end else begin
        for (int i = 0; i < NI; i++) begin
          if (en) begin
            n_en[i]++;
            any_en[i] = 1'b1;
            tk[i] = (n_en[i] % CDIV[i]) == 0;
          end else begin
            tk[i] = 1'b0;
          end
        end
        if (c == MID_RST) begin
          #3 rst = 1'b1;
          hold = 3;
          model_reset();
          $display("reset asserted at %0t", $time);
        end
        push_state();
      end
      #1;
      en = (c + 1 >= HOLD_AT && c + 1 < HOLD_AT + 10) ? 1'b0 : ($urandom_range(15) != 0);
    end
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending snapshots, need 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Monitor: one expected snapshot per clk edge, compared on the falling edge.
  initial begin
    trio_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int i = 0; i < NI; i++) begin
          total++;
          if (act_w[i] !== e[i]) begin
            bad++;
            $display("FAIL snap inst%0d t=%0t: got x=%0d y=%0d von=%b hs=%b vs=%b tick=%b fs=%b, need x=%0d y=%0d von=%b hs=%b vs=%b tick=%b fs=%b",
                     i, $time, act_w[i].x, act_w[i].y, act_w[i].von, act_w[i].hs, act_w[i].vs,
                     act_w[i].tick, act_w[i].fs, e[i].x, e[i].y, e[i].von, e[i].hs, e[i].vs,
                     e[i].tick, e[i].fs);
          end
          if (e[i].fs)
            $display("frame inst%0d at t=%0t x=%0d y=%0d", i, $time, act_w[i].x, act_w[i].y);
        end
      end
    end
  end

endmodule
